// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared fetch FSM encodings, reset PC default and offset sign-extension
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Wide result so callers can truncate to any PC width.
   function automatic logic [63:0] sext16(input logic [15:0] v);
      return {{48{v[15]}}, v};
   endfunction

endpackage

// File: rtl/pc_hist_pipe.sv
// rtl/pc_hist_pipe.sv - shift register of {valid,pc} tracking fetched instructions up to branch resolution
module pc_hist_pipe #(
   parameter int DEPTH = 2,
   parameter int PC_W  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            shift,
   input  logic            clear,
   input  logic            in_valid,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   output logic [PC_W-1:0] out_pc
);

   logic [DEPTH-1:0] valid_q;
   logic [PC_W-1:0]  pc_q [DEPTH];

   // Clear only kills valid bits; stale PCs are harmless behind them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
      end else if (clear) begin
         valid_q <= '0;
      end else if (shift) begin
         valid_q[0] <= in_valid;
         pc_q[0]    <= in_pc;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            pc_q[i]    <= pc_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_pc    = pc_q[DEPTH-1];

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, imem req/ack fetch FSM, skid buffer and branch redirect
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int              PC_W       = 32,
   parameter int              INSTR_W    = 32,
   parameter int              BRANCH_LAT = 2,
   parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEFAULT_RESET_PC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               branch,
   input  logic [15:0]        offset_in,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               fetch_valid,
   output logic [PC_W-1:0]    pc_ex,
   output logic [PC_W-1:0]    link_addr,
   output logic               flush
);

   fetch_state_t       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d, addr_d, target, fire_pc, skid_pc_q;
   logic               req_d, accept, ack_take, launch, hist_valid, fire;
   logic               skid_valid_q;
   logic [INSTR_W-1:0] skid_data_q;

   assign target    = pc_ex + PC_W'(sext16(offset_in));
   assign link_addr = pc_ex + PC_W'(1);
   assign accept    = branch && !stall && hist_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_d    = imem_req;
      addr_d   = imem_addr;
      ack_take = 1'b0;
      launch   = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            ack_take = imem_req && imem_ack && !accept;
            if (accept)        pc_d = target;
            else if (ack_take) pc_d = pc_q + PC_W'(1);
            if (imem_req && imem_ack) req_d = 1'b0;
            // Skid drop on accept frees the slot for the target fetch immediately.
            launch = (!imem_req || imem_ack) && !stall && (!skid_valid_q || accept);
            if (accept && imem_req && !imem_ack) state_d = ST_DISCARD;
         end
         ST_DISCARD: begin
            if (imem_ack) begin
               req_d   = 1'b0;
               state_d = ST_FETCH;
               launch  = !stall;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (launch) begin
         req_d  = 1'b1;
         addr_d = pc_d;
      end
   end

   assign fire    = !accept && !stall && (skid_valid_q || ack_take);
   assign fire_pc = skid_valid_q ? skid_pc_q : imem_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         imem_req     <= 1'b0;
         imem_addr    <= RESET_PC;
         instr        <= '0;
         fetch_valid  <= 1'b0;
         flush        <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_pc_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         imem_req    <= req_d;
         imem_addr   <= addr_d;
         flush       <= accept;
         fetch_valid <= 1'b0;
         if (accept) begin
            skid_valid_q <= 1'b0;
         end else if (!stall && skid_valid_q) begin
            instr        <= skid_data_q;
            fetch_valid  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else if (ack_take && !stall) begin
            instr       <= imem_rdata;
            fetch_valid <= 1'b1;
         end else if (ack_take) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= imem_rdata;
            skid_pc_q    <= imem_addr;
         end
      end
   end

   pc_hist_pipe #(
      .DEPTH (BRANCH_LAT),
      .PC_W  (PC_W)
   ) u_hist (
      .clk       (clk),
      .rst       (rst),
      .shift     (!stall),
      .clear     (accept),
      .in_valid  (fire),
      .in_pc     (fire_pc),
      .out_valid (hist_valid),
      .out_pc    (pc_ex)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst, stall, branch;
   logic [15:0] offset_in;
   logic        imem_req, imem_ack, fetch_valid, flush;
   logic [31:0] imem_addr, imem_rdata, instr, pc_ex, link_addr;
   logic        auto_ack, man_ack;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_ack   = auto_ack ? imem_req : man_ack;
   assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

   pc_sequencer #(
      .PC_W       (32),
      .INSTR_W    (32),
      .BRANCH_LAT (2),
      .RESET_PC   (32'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .branch      (branch),
      .offset_in   (offset_in),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .fetch_valid (fetch_valid),
      .pc_ex       (pc_ex),
      .link_addr   (link_addr),
      .flush       (flush)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch = 1'b0; offset_in = 16'h0;
      auto_ack = 1'b0; man_ack = 1'b0;
      tick(); tick();
      check("rst_req",   64'(imem_req),    64'(0));
      check("rst_addr",  64'(imem_addr),   64'(0));
      check("rst_instr", 64'(instr),       64'(0));
      check("rst_fv",    64'(fetch_valid), 64'(0));
      check("rst_flush", 64'(flush),       64'(0));
      check("rst_pc_ex", 64'(pc_ex),       64'(0));
      check("rst_link",  64'(link_addr),   64'(1));

      // Zero-wait acks: back-to-back sequential fetch.
      rst = 1'b0; auto_ack = 1'b1;
      tick();
      check("idle_req", 64'(imem_req), 64'(0));
      for (int k = 2; k <= 20; k++) begin
         tick();
         check("seq_addr", 64'(imem_addr), 64'(k - 2));
         check("seq_req",  64'(imem_req),  64'(1));
         if (k >= 3) begin
            check("seq_fv",    64'(fetch_valid), 64'(1));
            check("seq_instr", 64'(instr),       64'({16'hC0DE, 16'(k - 3)}));
         end
         if (k >= 4) check("seq_pc_ex", 64'(pc_ex), 64'(k - 4));
      end
      check("br1_link", 64'(link_addr), 64'(32'h11));

      // Taken branch -4 from pc_ex 0x10 with ack in the same cycle.
      branch = 1'b1; offset_in = 16'hFFFC;
      tick();
      check("br1_addr",  64'(imem_addr),   64'(32'h0C));
      check("br1_req",   64'(imem_req),    64'(1));
      check("br1_flush", 64'(flush),       64'(1));
      check("br1_fv",    64'(fetch_valid), 64'(0));
      tick();
      check("shadow_flush", 64'(flush),       64'(0));
      check("shadow_addr",  64'(imem_addr),   64'(32'h0D));
      check("tgt_fv",       64'(fetch_valid), 64'(1));
      check("tgt_instr",    64'(instr),       64'(32'hC0DE000C));
      branch = 1'b0;
      repeat (5) tick();
      check("br2_addr",  64'(imem_addr), 64'(32'h12));
      check("br2_pc_ex", 64'(pc_ex),     64'(32'h10));

      // Branch while request to 0x12 is outstanding.
      auto_ack = 1'b0; man_ack = 1'b0; branch = 1'b1; offset_in = 16'h0010;
      tick();
      check("disc_flush", 64'(flush),       64'(1));
      check("disc_req",   64'(imem_req),    64'(1));
      check("disc_addr",  64'(imem_addr),   64'(32'h12));
      check("disc_fv",    64'(fetch_valid), 64'(0));
      branch = 1'b0;
      repeat (2) begin
         tick();
         check("disc_hold_req",   64'(imem_req),    64'(1));
         check("disc_hold_addr",  64'(imem_addr),   64'(32'h12));
         check("disc_hold_fv",    64'(fetch_valid), 64'(0));
         check("disc_hold_flush", 64'(flush),       64'(0));
      end
      man_ack = 1'b1;
      tick();
      check("disc_tgt_addr", 64'(imem_addr),   64'(32'h20));
      check("disc_tgt_req",  64'(imem_req),    64'(1));
      check("disc_drop_fv",  64'(fetch_valid), 64'(0));

      // Ack delayed three cycles.
      man_ack = 1'b0;
      repeat (3) begin
         tick();
         check("wait_addr", 64'(imem_addr),   64'(32'h20));
         check("wait_req",  64'(imem_req),    64'(1));
         check("wait_fv",   64'(fetch_valid), 64'(0));
      end
      man_ack = 1'b1;
      tick();
      check("late_fv",    64'(fetch_valid), 64'(1));
      check("late_instr", 64'(instr),       64'(32'hC0DE0020));
      check("late_addr",  64'(imem_addr),   64'(32'h21));

      // Ack under stall lands in the skid buffer.
      stall = 1'b1;
      tick();
      check("skid_fv",  64'(fetch_valid), 64'(0));
      check("skid_req", 64'(imem_req),    64'(0));
      man_ack = 1'b0;
      tick();
      check("skid_hold_fv",  64'(fetch_valid), 64'(0));
      check("skid_hold_req", 64'(imem_req),    64'(0));
      stall = 1'b0;
      tick();
      check("skid_out_fv",    64'(fetch_valid), 64'(1));
      check("skid_out_instr", 64'(instr),       64'(32'hC0DE0021));
      check("skid_out_req",   64'(imem_req),    64'(0));
      check("skid_pc_ex",     64'(pc_ex),       64'(32'h20));
      tick();
      check("post_skid_req",  64'(imem_req),    64'(1));
      check("post_skid_addr", 64'(imem_addr),   64'(32'h22));
      check("post_skid_fv",   64'(fetch_valid), 64'(0));
      check("post_skid_link", 64'(link_addr),   64'(32'h22));

      // Branch to 0xFFFFFFFF, then the increment wraps to 0.
      auto_ack = 1'b1; branch = 1'b1; offset_in = 16'hFFDE;
      tick();
      check("wrap_tgt",   64'(imem_addr),   64'(32'hFFFF_FFFF));
      check("wrap_flush", 64'(flush),       64'(1));
      check("wrap_fv",    64'(fetch_valid), 64'(0));
      branch = 1'b0;
      tick();
      check("wrap_instr", 64'(instr),       64'(32'hC0DEFFFF));
      check("wrap_fv2",   64'(fetch_valid), 64'(1));
      check("wrap_addr",  64'(imem_addr),   64'(0));
      check("wrap_flush2", 64'(flush),      64'(0));

      // Asynchronous reset mid-request.
      rst = 1'b1;
      #1;
      check("async_req",  64'(imem_req),  64'(0));
      check("async_addr", 64'(imem_addr), 64'(0));
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
